pfd_sync_detector: RTL and testbench

- Clocked phase-frequency detector comparing rising edges of the reference `link` against the locally generated `vco` square wave.
- Produces classic up/dn pulses plus complements, and a 2-bit `setting` summary (pulse-active, direction).
- The PLL core times pulse length and adjusts VCO frequency from these outputs.
- Sits between the link/VCO signals and the PLL frequency-update logic; runs on the 100 MHz system clock.

---
 rtl/pfd_pkg.sv | 16 +
 rtl/pfd_edge_sync.sv | 27 ++
 rtl/pfd_sync_detector.sv | 142 ++++++++++++++
 tb/tb_pfd_sync_detector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pfd_pkg.sv
// Shared types and constants for the pfd_sync_detector phase-frequency detector.
package pfd_pkg;

  typedef enum logic [1:0] {
    PFD_IDLE = 2'b00,
    PFD_UP   = 2'b01,
    PFD_DN   = 2'b10
  } pfd_state_t;

  localparam int SETTING_ACTIVE = 0;
  localparam int SETTING_DIR    = 1;

  // Width of the lock-detect pulse-width and consecutive-good counters.
  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/pfd_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input plus a registered rising-edge strobe.
module pfd_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: every flop, synchronizer included, is cleared so an input already high at release yields one edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/pfd_sync_detector.sv
// Clocked PFD comparing link vs vco rising edges; up/dn/setting outputs all registered.
// Optional lock detector enabled by defining PFD_LOCK_DETECT_EN.
module pfd_sync_detector
  import pfd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef PFD_LOCK_DETECT_EN
  ,
  parameter int LOCK_WIDTH  = 4,
  parameter int LOCK_COUNT  = 8
`endif
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       link,
  input  logic       vco,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb,
  output logic [1:0] setting
`ifdef PFD_LOCK_DETECT_EN
  ,
  output logic       locked
`endif
);

  logic       link_rise;
  logic       vco_rise;
  pfd_state_t state;

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_link_sync (
    .clk  (clk),
    .nrst (nrst),
    .din  (link),
    .rise (link_rise)
  );

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vco_sync (
    .clk  (clk),
    .nrst (nrst),
    .din  (vco),
    .rise (vco_rise)
  );

  // NOTE: outputs are loaded alongside the state with <=, so they are flops rather than decodes of state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= PFD_IDLE;
      up      <= 1'b0;
      dn      <= 1'b0;
      upb     <= 1'b1;
      dnb     <= 1'b1;
      setting <= 2'b00;
    end else begin
      case (state)
        PFD_IDLE: begin
          if (link_rise && !vco_rise) begin
            state                   <= PFD_UP;
            up                      <= 1'b1;
            upb                     <= 1'b0;
            setting[SETTING_ACTIVE] <= 1'b1;
            setting[SETTING_DIR]    <= 1'b0;
          end else if (vco_rise && !link_rise) begin
            state                   <= PFD_DN;
            dn                      <= 1'b1;
            dnb                     <= 1'b0;
            setting[SETTING_ACTIVE] <= 1'b1;
            setting[SETTING_DIR]    <= 1'b1;
          end
        end
        PFD_UP: begin
          if (vco_rise) begin
            state                   <= PFD_IDLE;
            up                      <= 1'b0;
            upb                     <= 1'b1;
            setting[SETTING_ACTIVE] <= 1'b0;
          end
        end
        PFD_DN: begin
          if (link_rise) begin
            state                   <= PFD_IDLE;
            dn                      <= 1'b0;
            dnb                     <= 1'b1;
            setting[SETTING_ACTIVE] <= 1'b0;
          end
        end
        default: begin
          state   <= PFD_IDLE;
          up      <= 1'b0;
          dn      <= 1'b0;
          upb     <= 1'b1;
          dnb     <= 1'b1;
          setting <= 2'b00;
        end
      endcase
    end
  end

`ifdef PFD_LOCK_DETECT_EN
  localparam logic [LOCK_CNT_W-1:0] LW     = LOCK_CNT_W'(LOCK_WIDTH);
  localparam logic [LOCK_CNT_W-1:0] LC     = LOCK_CNT_W'(LOCK_COUNT);
  localparam logic [LOCK_CNT_W-1:0] CNT_MAX = '1;

  logic [LOCK_CNT_W-1:0] width_q;
  logic [LOCK_CNT_W-1:0] good_q;
  logic [LOCK_CNT_W-1:0] good_nxt;
  logic                  pulse_end;
  logic                  coinc;
  logic                  good_pulse;

  assign pulse_end  = ((state == PFD_UP) && vco_rise) || ((state == PFD_DN) && link_rise);
  assign coinc      = (state == PFD_IDLE) && link_rise && vco_rise;
  // width_q lags the true width by one at the closing edge, hence the strict compare.
  assign good_pulse = coinc || (width_q < LW);
  assign good_nxt   = (good_q < LC) ? good_q + 1'b1 : good_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      width_q <= '0;
      good_q  <= '0;
      locked  <= 1'b0;
    end else begin
      if (setting[SETTING_ACTIVE]) begin
        width_q <= (width_q == CNT_MAX) ? width_q : width_q + 1'b1;
      end else begin
        width_q <= '0;
      end
      if (pulse_end || coinc) begin
        if (good_pulse) begin
          good_q <= good_nxt;
          locked <= (good_nxt == LC);
        end else begin
          good_q <= '0;
          locked <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pfd_sync_detector.sv
// Self-checking bench for pfd_sync_detector: directed scenarios plus random square waves vs a delay-line model.
module tb_pfd_sync_detector;

  localparam int S  = 2;
  localparam int LW = 4;
  localparam int LC = 8;

  logic       clk;
  logic       nrst;
  logic       link;
  logic       vco;
  logic       up;
  logic       dn;
  logic       upb;
  logic       dnb;
  logic [1:0] setting;
`ifdef PFD_LOCK_DETECT_EN
  logic       locked;
`endif

  pfd_sync_detector #(
    .SYNC_STAGES (S)
`ifdef PFD_LOCK_DETECT_EN
    ,
    .LOCK_WIDTH  (LW),
    .LOCK_COUNT  (LC)
`endif
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .link    (link),
    .vco     (vco),
    .up      (up),
    .dn      (dn),
    .upb     (upb),
    .dnb     (dnb),
    .setting (setting)
`ifdef PFD_LOCK_DETECT_EN
    ,
    .locked  (locked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: rising edges enter a delay line and act on the pulse rules S+1 clocks later.
  bit lq[$];
  bit vq[$];
  bit l_prev, v_prev;
  bit m_up, m_dn, m_dir, m_locked;
  int m_width, m_good;

  int cyc = 0;
  int dut_up_n, dut_dn_n, dut_dnb_low, first_up;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    lq.delete();
    vq.delete();
    l_prev = 0; v_prev = 0;
    m_up = 0; m_dn = 0; m_dir = 0;
    m_width = 0; m_good = 0; m_locked = 0;
  endtask

  task automatic lock_event(input int w);
    if (w <= LW) begin
      if (m_good < LC) m_good++;
      m_locked = (m_good == LC);
    end else begin
      m_good = 0;
      m_locked = 0;
    end
  endtask

  task automatic clear_counts();
    dut_up_n = 0; dut_dn_n = 0; dut_dnb_low = 0; first_up = -1;
  endtask

  task automatic check_outputs();
    check("up", up, m_up);
    check("dn", dn, m_dn);
    check("upb", upb, !m_up);
    check("dnb", dnb, !m_dn);
    check("setting", setting, {m_dir, m_up | m_dn});
`ifdef PFD_LOCK_DETECT_EN
    check("locked", locked, m_locked);
`endif
  endtask

  task automatic tick();
    bit el, ev;
    @(posedge clk);
    cyc++;
    lq.push_back(link & !l_prev);
    vq.push_back(vco & !v_prev);
    l_prev = link;
    v_prev = vco;
    el = 0; ev = 0;
    if (lq.size() == S + 2) begin
      el = lq.pop_front();
      ev = vq.pop_front();
    end
    if (m_up || m_dn) m_width++;
    if (!m_up && !m_dn) begin
      if (el && ev) lock_event(0);
      else if (el) begin m_up = 1; m_dir = 0; m_width = 0; end
      else if (ev) begin m_dn = 1; m_dir = 1; m_width = 0; end
    end else if (m_up && ev) begin
      m_up = 0;
      lock_event(m_width);
    end else if (m_dn && el) begin
      m_dn = 0;
      lock_event(m_width);
    end
    #1;
    if (up === 1'b1) begin
      dut_up_n++;
      if (first_up < 0) first_up = cyc;
    end
    if (dn === 1'b1) dut_dn_n++;
    if (dnb === 1'b0) dut_dnb_low++;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int drive_cyc;
  int lt, vt;

  initial begin
    // Reset with both inputs high.
    link = 1'b1; vco = 1'b1;
    nrst = 1'b1;
    #1 nrst = 1'b0;
    #12;
    model_reset();
    clear_counts();
    check_outputs();
    @(negedge clk);
    nrst = 1'b1;

    // Coincident edges at release: no pulse.
    run(10);
    check("coinc_release_pulses", dut_up_n + dut_dn_n, 0);

    // Link leads vco by 20.
    link = 0; vco = 0; run(5);
    clear_counts();
    link = 1; drive_cyc = cyc + 1; run(20);
    vco = 1; run(10);
    check("lead_up_width", dut_up_n, 20);
    check("lead_up_latency", first_up - drive_cyc, S + 1);
    check("lead_no_dn", dut_dn_n, 0);

    // Vco leads link by 5.
    link = 0; vco = 0; run(5);
    clear_counts();
    vco = 1; run(5);
    link = 1; run(10);
    check("vco_lead_dnb_low", dut_dnb_low, 5);
    check("vco_lead_no_up", dut_up_n, 0);

    // Same-cycle edges.
    link = 0; vco = 0; run(5);
    clear_counts();
    link = 1; vco = 1; run(10);
    check("same_cycle_pulses", dut_up_n + dut_dn_n, 0);

    // Link rises twice before vco: single pulse of 30.
    link = 0; vco = 0; run(5);
    clear_counts();
    link = 1; run(5);
    link = 0; run(5);
    link = 1; run(20);
    vco = 1; run(10);
    check("repeat_lead_width", dut_up_n, 30);

    // Reset in the middle of an up pulse.
    link = 0; vco = 0; run(5);
    link = 1; run(S + 1 + 8);
    check("mid_pulse_up_before", up, 1'b1);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    link = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    clear_counts();
    run(10);
    check("post_reset_no_pulse", dut_up_n + dut_dn_n, 0);
    vco = 1; run(5);
    link = 1; run(10);
    check("post_reset_new_dn", dut_dn_n, 5);

`ifdef PFD_LOCK_DETECT_EN
    link = 0; vco = 0; run(5);
    for (int p = 0; p < LC; p++) begin
      link = 1; run(2);
      vco = 1; run(S + 3);
      link = 0; vco = 0; run(3);
    end
    check("lock_after_good", locked, 1'b1);
    link = 1; run(10);
    vco = 1; run(S + 3);
    link = 0; vco = 0; run(3);
    check("lock_lost_wide", locked, 1'b0);
`endif

    // Random square waves with independent half-periods.
    lt = $urandom_range(1, 25);
    vt = $urandom_range(1, 25);
    for (int i = 0; i < 3000; i++) begin
      if (--lt == 0) begin link = !link; lt = $urandom_range(1, 25); end
      if (--vt == 0) begin vco = !vco; vt = $urandom_range(1, 25); end
      if ($urandom_range(0, 63) == 0) begin
        link = 1'b0; vco = 1'b0;
        lt = $urandom_range(2, 25); vt = lt;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
